// File: rtl/serial_adder_if.sv
// Start/busy/done handshake and operand/result bus of the bit-serial adder.
// master: controller side (drives start, a, b, cin, sub).
// slave:  adder side (drives busy, done, sum, cout, overflow).
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell, a carry flop and operand
// shift registers, WIDTH cycles per operation.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - slave side of serial_adder_if:
//           start/a/b/cin/sub in, busy/done/sum/cout/overflow out (registered)
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             bit_s;
  logic             carry_nxt;
  logic             last_bit;

  // Single full-adder cell on the operand LSBs.
  always_comb begin
    bit_s     = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    carry_nxt = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
    last_bit  = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          // Subtraction is A + ~B + 1: invert B and force the carry-in.
          a_sh_d  = bus.a;
          b_sh_d  = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub | bus.cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        res_d   = {bit_s, res_q[WIDTH-1:1]};
        carry_d = carry_nxt;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_bit) begin
          // carry_q here is the carry into the MSB.
          sum_d   = {bit_s, res_q[WIDTH-1:1]};
          cout_d  = carry_nxt;
          ovf_d   = carry_q ^ carry_nxt;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH = 2, 8, 16 and 32.
module tb_serial_adder;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    int          e;
    int          w;
    int          k;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_drv = 1'b0;
  logic [63:0] a_drv = '0;
  logic [63:0] b_drv = '0;
  logic        cin_drv = 1'b0;
  logic        sub_drv = 1'b0;
  int          sel = 1;
  int          cur_w = 8;
  int          cyc = 0;
  int          free_edge = 0;
  int          n_acc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  exp_t        held[4];

  logic [63:0] sum_v [4];
  logic        cout_v [4];
  logic        ovf_v [4];
  logic        busy_v [4];
  logic        done_v [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder_if #(.WIDTH(2))  if2  ();
  serial_adder_if #(.WIDTH(8))  if8  ();
  serial_adder_if #(.WIDTH(16)) if16 ();
  serial_adder_if #(.WIDTH(32)) if32 ();

  serial_adder #(.WIDTH(2))  u2  (.clk(clk), .rst_n(rst_n), .bus(if2));
  serial_adder #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  serial_adder #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(if16));
  serial_adder #(.WIDTH(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(if32));

  assign if2.start  = start_drv & (sel == 0);
  assign if8.start  = start_drv & (sel == 1);
  assign if16.start = start_drv & (sel == 2);
  assign if32.start = start_drv & (sel == 3);
  assign if2.a  = a_drv[1:0];   assign if2.b  = b_drv[1:0];
  assign if8.a  = a_drv[7:0];   assign if8.b  = b_drv[7:0];
  assign if16.a = a_drv[15:0];  assign if16.b = b_drv[15:0];
  assign if32.a = a_drv[31:0];  assign if32.b = b_drv[31:0];
  assign if2.cin  = cin_drv;  assign if2.sub  = sub_drv;
  assign if8.cin  = cin_drv;  assign if8.sub  = sub_drv;
  assign if16.cin = cin_drv;  assign if16.sub = sub_drv;
  assign if32.cin = cin_drv;  assign if32.sub = sub_drv;

  assign sum_v[0] = 64'(if2.sum);   assign sum_v[1] = 64'(if8.sum);
  assign sum_v[2] = 64'(if16.sum);  assign sum_v[3] = 64'(if32.sum);
  assign cout_v[0] = if2.cout;  assign cout_v[1] = if8.cout;
  assign cout_v[2] = if16.cout; assign cout_v[3] = if32.cout;
  assign ovf_v[0] = if2.overflow;  assign ovf_v[1] = if8.overflow;
  assign ovf_v[2] = if16.overflow; assign ovf_v[3] = if32.overflow;
  assign busy_v[0] = if2.busy;  assign busy_v[1] = if8.busy;
  assign busy_v[2] = if16.busy; assign busy_v[3] = if32.busy;
  assign done_v[0] = if2.done;  assign done_v[1] = if8.done;
  assign done_v[2] = if16.done; assign done_v[3] = if32.done;

  function automatic int width_of(input int s);
    case (s)
      0:       return 2;
      1:       return 8;
      2:       return 16;
      default: return 32;
    endcase
  endfunction

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic cin, input logic sub,
                                 input int w, input int e, input int k);
    exp_t        r;
    logic [63:0] mask;
    longint      ua, ub, sa, sb, sr, full, lim;
    mask = (64'd1 << w) - 64'd1;
    ua   = longint'(a & mask);
    ub   = longint'(b & mask);
    lim  = longint'(1) << (w - 1);
    sa   = (ua >= lim) ? ua - (longint'(1) << w) : ua;
    sb   = (ub >= lim) ? ub - (longint'(1) << w) : ub;
    if (sub) begin
      r.sum  = 64'(ua - ub) & mask;
      r.cout = (ua >= ub);
      sr     = sa - sb;
    end else begin
      full   = ua + ub + longint'(cin);
      r.sum  = 64'(full) & mask;
      r.cout = ((full >> w) & longint'(1)) != 0;
      sr     = sa + sb + longint'(cin);
    end
    r.ovf = (sr >= lim) || (sr < -lim);
    r.e   = e;
    r.w   = w;
    r.k   = k;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // One clock of stimulus; the model decides whether the start is taken.
  task automatic drive(input logic st, input logic [63:0] a, input logic [63:0] b,
                       input logic cin, input logic sub);
    int e;
    @(posedge clk);
    #1;
    start_drv = st;
    a_drv     = a;
    b_drv     = b;
    cin_drv   = cin;
    sub_drv   = sub;
    e = cyc + 1;
    if (st && e >= free_edge) begin
      exp_q.push_back(model(a, b, cin, sub, cur_w, e, sel));
      free_edge = e + cur_w + 1;
      n_acc++;
    end
  endtask

  task automatic drive_rand(input logic st);
    drive(st, {$urandom(), $urandom()}, {$urandom(), $urandom()},
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) drive_rand(1'b0);
    drive_rand(1'b0);
    drive_rand(1'b0);
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                        input logic cin, input logic sub);
    drive(1'b1, a, b, cin, sub);
    drain();
  endtask

  // Monitor: compares every DUT's handshake and held outputs each cycle.
  always @(negedge clk) begin
    exp_t f;
    bit   exp_done;
    bit   exp_busy;
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) held[k] = '{sum: '0, cout: 1'b0, ovf: 1'b0, e: 0, w: 0, k: k};
    end
    exp_done = (exp_q.size() > 0) && (cyc == exp_q[0].e + exp_q[0].w);
    for (int k = 0; k < 4; k++) begin
      exp_busy = (exp_q.size() > 0) && (exp_q[0].k == k) &&
                 (cyc >= exp_q[0].e) && (cyc < exp_q[0].e + exp_q[0].w);
      chk($sformatf("busy[w%0d]", width_of(k)), 64'(busy_v[k]), 64'(exp_busy));
      chk($sformatf("done[w%0d]", width_of(k)), 64'(done_v[k]),
          64'(exp_done && exp_q[0].k == k));
    end
    if (exp_done) begin
      f = exp_q.pop_front();
      held[f.k] = f;
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("sum[w%0d]", width_of(k)),  sum_v[k],         held[k].sum);
      chk($sformatf("cout[w%0d]", width_of(k)), 64'(cout_v[k]),   64'(held[k].cout));
      chk($sformatf("ovf[w%0d]", width_of(k)),  64'(ovf_v[k]),    64'(held[k].ovf));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 4; k++) held[k] = '{sum: '0, cout: 1'b0, ovf: 1'b0, e: 0, w: 0, k: k};
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed cases at WIDTH=8.
    sel = 1;
    cur_w = 8;
    run_op(64'h0F, 64'h01, 1'b0, 1'b0);
    run_op(64'hFF, 64'h01, 1'b0, 1'b0);
    run_op(64'h7E, 64'h01, 1'b1, 1'b0);
    run_op(64'h05, 64'h07, 1'b1, 1'b1);
    run_op(64'h80, 64'h01, 1'b0, 1'b1);

    // start during RUN with different operands is ignored.
    drive(1'b1, 64'h12, 64'h34, 1'b0, 1'b0);
    repeat (3) drive_rand(1'b0);
    drive(1'b1, 64'h55, 64'h66, 1'b1, 1'b1);
    drain();

    // start held high: back-to-back results every WIDTH+1 cycles.
    repeat (45) drive_rand(1'b1);
    drain();

    // Reset in the middle of an operation.
    drive(1'b1, 64'hA5, 64'h3C, 1'b0, 1'b0);
    repeat (4) drive_rand(1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    free_edge = 0;
    #1;
    chk("rst_sum",  64'(if8.sum),      64'd0);
    chk("rst_cout", 64'(if8.cout),     64'd0);
    chk("rst_ovf",  64'(if8.overflow), 64'd0);
    chk("rst_busy", 64'(if8.busy),     64'd0);
    chk("rst_done", 64'(if8.done),     64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) drive_rand(1'b0);
    run_op(64'h33, 64'h44, 1'b1, 1'b0);

    // Random sweep at every instantiated width.
    for (int s = 0; s < 4; s++) begin
      sel   = s;
      cur_w = width_of(s);
      n_acc = 0;
      for (int i = 0; i < 20000 && n_acc < 200; i++)
        drive_rand(1'($urandom_range(0, 3) != 0));
      chk($sformatf("accepted[w%0d]", cur_w), 64'(n_acc), 64'd200);
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder/subtractor built around a single full-adder cell, a carry flip-flop and operand shift registers. It takes over the half-adder exercises as the first sequential arithmetic block of the series. It trades latency, WIDTH cycles per operation, for a datapath of one bit plus registers. A start/busy/done handshake lets a controller or testbench drive it directly.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..64.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a new operation; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A, captured on the accepting edge.
- b  input  WIDTH  operand B, captured on the accepting edge.
- cin  input  1  carry-in for add mode; ignored when sub=1.
- sub  input  1  0 = A+B+cin, 1 = A−B (A + ~B + 1), captured with the operands.
- busy  output  1  high while bits are being processed (RUN).
- done  output  1  one-cycle pulse: result valid.
- sum  output  WIDTH  result; held stable from done until the next accepted start.
- cout  output  1  carry out of the MSB; in sub mode 1 = no borrow (A ≥ B unsigned).
- overflow  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- Reset (rst_n=0, takes effect immediately):
  - state=IDLE.
  - busy, done, sum, cout and overflow all =0.
  - Bit counter, shift registers and carry flop all =0.
- States:
  - IDLE: start=1 → capture operands, go to RUN. Otherwise stay.
  - RUN: process one bit per cycle. After the WIDTH-th bit → DONE.
  - DONE: done=1 for this cycle only. start=1 → capture and go to RUN (back-to-back). Otherwise → IDLE.
- Capture:
  - A_sh ← a.
  - B_sh ← sub ? ~b : b.
  - carry ← sub ? 1 : cin.
  - Bit counter ← 0.
  - Mode is latched. Later changes to inputs have no effect until the next capture.
- Each RUN cycle:
  - s = A_sh[0] ^ B_sh[0] ^ carry.
  - carry ← majority(A_sh[0], B_sh[0], carry).
  - A_sh and B_sh shift right by one.
  - s shifts into the MSB of the internal result register.
  - Counter increments.
- On the last bit (counter = WIDTH−1), in addition:
  - Record the carry into the MSB (the pre-update carry) for overflow.
  - Transfer the result register, the final carry and the overflow flag to sum, cout and overflow.
- Outputs sum, cout and overflow change only on the transfer edge. In all other states they hold.
- start while in RUN is ignored: no capture, no restart, no error.
- All arithmetic is modulo 2^WIDTH. No saturation.

## Timing
- Edge E0: start accepted. busy=1 from E0 through E_WIDTH.
- Edges E1..E_WIDTH: bit i is processed at edge E(i+1).
- After E_WIDTH:
  - busy=0, done=1, and sum, cout and overflow are valid in the same cycle.
- Latency from the accepting edge to done high is WIDTH cycles.
- Throughput is one result per WIDTH+1 cycles when start is held high, because DONE accepts the next start.
- Reset asserted mid-RUN:
  - Operation aborts. Outputs return to 0 asynchronously.
  - No done pulse follows.
  - After release, a start is required before any new result.
- done is never high in two consecutive cycles.
- busy and done are never high together.

## Test plan
- Reset and basic add, WIDTH=8:
  - Stimulus: after reset release, a=0x0F, b=0x01, cin=0, sub=0, start pulse.
  - Required: sum, cout and overflow read 0 from reset up to done. busy high for 8 cycles, then done for 1 cycle with sum=0x10, cout=0, overflow=0.
- Unsigned wrap:
  - Stimulus: 0xFF+0x01, cin=0.
  - Required: sum=0x00, cout=1, overflow=0.
- Signed overflow with carry-in:
  - Stimulus: 0x7E+0x01, cin=1.
  - Required: sum=0x80, cout=0, overflow=1.
- Subtract with borrow:
  - Stimulus: sub=1, a=0x05, b=0x07, cin=1 (cin must be ignored).
  - Required: sum=0xFE, cout=0, overflow=0.
  - Then: 0x80−0x01 → sum=0x7F, cout=1, overflow=1.
- Handshake corners:
  - Stimulus: start pulsed mid-RUN with different operands.
  - Required: ignored, and the original result is delivered.
  - Stimulus: start held high continuously.
  - Required: done every 9 cycles, each result correct.
  - Stimulus: rst_n low at bit 4.
  - Required: all outputs 0 immediately, no done pulse.
- Parameter sweep:
  - Stimulus: WIDTH=2, 16, 32, each with 200 random operations, result compared against a+b+cin and a−b.
  - Required: all results match, and latency equals WIDTH every time.
